// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, load-type encodings and write-enable constant for the write-back stage
package wb_stage_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam logic [2:0] LD_ALU = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LW  = 3'd5;
  localparam logic [2:0] LD_LWL = 3'd6;
  localparam logic [2:0] LD_LWR = 3'd7;
  localparam logic [3:0] WEN_ALL = 4'b1111;
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load extraction (byte/half extension) and LWL/LWR merge, little-endian
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]            ld_type,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] rt_value,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] wdata
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] lwl, lwr;
  assign b = mem_rdata[8*addr_lo +: 8];
  assign h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  // LWL fills the high bytes of rt, LWR the low bytes
  assign lwl = addr_lo == 2'd0 ? {mem_rdata[7:0], rt_value[23:0]} :
               addr_lo == 2'd1 ? {mem_rdata[15:0], rt_value[15:0]} :
               addr_lo == 2'd2 ? {mem_rdata[23:0], rt_value[7:0]} : mem_rdata;
  assign lwr = addr_lo == 2'd0 ? mem_rdata :
               addr_lo == 2'd1 ? {rt_value[31:24], mem_rdata[31:8]} :
               addr_lo == 2'd2 ? {rt_value[31:16], mem_rdata[31:16]} :
                                 {rt_value[31:8], mem_rdata[31:24]};
  always_comb begin
    wdata = alu_result;
    case (ld_type)
      LD_LB:   wdata = {{24{b[7]}}, b};
      LD_LBU:  wdata = {24'd0, b};
      LD_LH:   wdata = {{16{h[15]}}, h};
      LD_LHU:  wdata = {16'd0, h};
      LD_LW:   wdata = mem_rdata;
      LD_LWL:  wdata = lwl;
      LD_LWR:  wdata = lwr;
      default: wdata = alu_result;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline register driving the register file write port and forwarding info
// Optional WB_DEBUG_EN adds debug_wb_* trace outputs mirroring the retired write.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ms_to_ws_valid,
  output logic                  ws_allowin,
  input  logic [31:0]           ms_pc,
  input  logic [ADDR_WIDTH-1:0] ms_dest,
  input  logic                  ms_rf_we,
  input  logic [2:0]            ms_ld_type,
  input  logic [1:0]            ms_addr_lo,
  input  logic [DATA_WIDTH-1:0] ms_alu_result,
  input  logic [DATA_WIDTH-1:0] ms_mem_rdata,
  input  logic [DATA_WIDTH-1:0] ms_rt_value,
  input  logic                  ws_flush,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [3:0]            rf_wen,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  ws_fwd_valid,
  output logic [ADDR_WIDTH-1:0] ws_fwd_dest,
  output logic [DATA_WIDTH-1:0] ws_fwd_data
`ifdef WB_DEBUG_EN
  ,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
`endif
);
  logic                  ws_valid, rf_we, wr;
  logic [ADDR_WIDTH-1:0] dest;
  logic [2:0]            ld_type;
  logic [1:0]            addr_lo;
  logic [DATA_WIDTH-1:0] alu_result, mem_rdata, rt_value;
  logic                  accept;
  assign accept = ms_to_ws_valid && !ws_flush;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid   <= 1'b0;
      dest       <= '0;
      rf_we      <= 1'b0;
      ld_type    <= '0;
      addr_lo    <= '0;
      alu_result <= '0;
      mem_rdata  <= '0;
      rt_value   <= '0;
    end else begin
      ws_valid <= accept;
      if (accept) begin
        dest       <= ms_dest;
        rf_we      <= ms_rf_we;
        ld_type    <= ms_ld_type;
        addr_lo    <= ms_addr_lo;
        alu_result <= ms_alu_result;
        mem_rdata  <= ms_mem_rdata;
        rt_value   <= ms_rt_value;
      end
    end
  end
  load_align u_align (
    .ld_type    (ld_type),
    .addr_lo    (addr_lo),
    .mem_rdata  (mem_rdata),
    .rt_value   (rt_value),
    .alu_result (alu_result),
    .wdata      (rf_wdata)
  );
  assign ws_allowin   = 1'b1;
  assign wr           = ws_valid && rf_we && dest != '0;
  assign rf_waddr     = dest;
  assign rf_wen       = wr ? WEN_ALL : 4'b0000;
  assign ws_fwd_valid = wr;
  assign ws_fwd_dest  = dest;
  assign ws_fwd_data  = rf_wdata;
`ifdef WB_DEBUG_EN
  logic [31:0] pc;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pc <= '0;
    else if (accept) pc <= ms_pc;
  end
  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = rf_wen;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  logic unused_pc;
  assign unused_pc = ^ms_pc;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven, scoreboarded bench for wb_stage
module tb_wb_stage;
  import wb_stage_pkg::*;
  logic        clk = 0, resetn = 0;
  logic        ms_to_ws_valid = 0, ws_allowin, ms_rf_we = 0, ws_flush = 0;
  logic [31:0] ms_pc = 0, ms_alu_result = 0, ms_mem_rdata = 0, ms_rt_value = 0;
  logic [4:0]  ms_dest = 0, rf_waddr, ws_fwd_dest;
  logic [2:0]  ms_ld_type = 0;
  logic [1:0]  ms_addr_lo = 0;
  logic [3:0]  rf_wen;
  logic [31:0] rf_wdata, ws_fwd_data;
  logic        ws_fwd_valid;
`ifdef WB_DEBUG_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
`endif
  wb_stage dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_rf_we(ms_rf_we), .ms_ld_type(ms_ld_type),
    .ms_addr_lo(ms_addr_lo), .ms_alu_result(ms_alu_result), .ms_mem_rdata(ms_mem_rdata),
    .ms_rt_value(ms_rt_value), .ws_flush(ws_flush), .rf_waddr(rf_waddr), .rf_wen(rf_wen),
    .rf_wdata(rf_wdata), .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest),
    .ws_fwd_data(ws_fwd_data)
`ifdef WB_DEBUG_EN
    , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ld; logic [1:0] a; logic [31:0] m, rt, alu; logic [4:0] dest; logic we;
    logic [31:0] wdata; logic [3:0] wen; logic fwd;
  } vec_t;
  typedef struct { logic [4:0] waddr; logic [3:0] wen; logic [31:0] wdata; logic fwd; } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t v[15];
  int n = 0, err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, exp_t x);
    chk({nm, ".wen"}, {28'd0, rf_wen}, {28'd0, x.wen});
    chk({nm, ".waddr"}, {27'd0, rf_waddr}, {27'd0, x.waddr});
    chk({nm, ".wdata"}, rf_wdata, x.wdata);
    chk({nm, ".fwd_valid"}, {31'd0, ws_fwd_valid}, {31'd0, x.fwd});
    chk({nm, ".fwd_dest"}, {27'd0, ws_fwd_dest}, {27'd0, x.waddr});
    chk({nm, ".fwd_data"}, ws_fwd_data, x.wdata);
  endtask

  task automatic drive(vec_t x, logic flush);
    ms_to_ws_valid = 1; ws_flush = flush;
    ms_ld_type = x.ld; ms_addr_lo = x.a; ms_mem_rdata = x.m; ms_rt_value = x.rt;
    ms_alu_result = x.alu; ms_dest = x.dest; ms_rf_we = x.we; ms_pc = {x.alu[29:0], 2'b00};
    if (!flush) sb.push_back('{x.dest, x.wen, x.wdata, x.fwd});
  endtask

  task automatic step_check(string nm);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      err++; n++;
      $display("FAIL %s scoreboard empty got %h want entry", nm, rf_wen);
    end else begin
      e = sb.pop_front();
      chk_out(nm, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{LD_LB,  2'd1, 32'h1234_80FF, 32'h0, 32'h0, 5'd8, 1'b1, 32'hFFFF_FF80, 4'hF, 1'b1};
    v[1]  = '{LD_LBU, 2'd1, 32'h1234_80FF, 32'h0, 32'h0, 5'd8, 1'b1, 32'h0000_0080, 4'hF, 1'b1};
    v[2]  = '{LD_LB,  2'd0, 32'h1234_80FF, 32'h0, 32'h0, 5'd9, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1};
    v[3]  = '{LD_LB,  2'd3, 32'h1234_80FF, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0000_0012, 4'hF, 1'b1};
    v[4]  = '{LD_LH,  2'd0, 32'h1234_80FF, 32'h0, 32'h0, 5'd10, 1'b1, 32'hFFFF_80FF, 4'hF, 1'b1};
    v[5]  = '{LD_LH,  2'd2, 32'hAABB_CCDD, 32'h0, 32'h0, 5'd10, 1'b1, 32'hFFFF_AABB, 4'hF, 1'b1};
    v[6]  = '{LD_LHU, 2'd3, 32'hAABB_CCDD, 32'h0, 32'h0, 5'd11, 1'b1, 32'h0000_AABB, 4'hF, 1'b1};
    v[7]  = '{LD_LW,  2'd0, 32'hAABB_CCDD, 32'h0, 32'h0, 5'd12, 1'b1, 32'hAABB_CCDD, 4'hF, 1'b1};
    v[8]  = '{LD_LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 5'd13, 1'b1, 32'hCCDD_3344, 4'hF, 1'b1};
    v[9]  = '{LD_LWL, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 5'd13, 1'b1, 32'hDD22_3344, 4'hF, 1'b1};
    v[10] = '{LD_LWL, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 5'd13, 1'b1, 32'hBBCC_DD44, 4'hF, 1'b1};
    v[11] = '{LD_LWR, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 5'd14, 1'b1, 32'h1122_AABB, 4'hF, 1'b1};
    v[12] = '{LD_LWR, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 5'd14, 1'b1, 32'h11AA_BBCC, 4'hF, 1'b1};
    v[13] = '{LD_LWR, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h0, 5'd14, 1'b1, 32'h1122_33AA, 4'hF, 1'b1};
    v[14] = '{LD_ALU, 2'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF, 4'h0, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", '{5'd0, 4'h0, 32'h0, 1'b0});
    chk("allowin", {31'd0, ws_allowin}, 32'd1);
    @(negedge clk) resetn = 1;

    foreach (v[i]) begin
      drive(v[i], 1'b0);
      step_check($sformatf("vec%0d", i));
    end

    // register write disabled
    drive('{LD_ALU, 2'd0, 32'h0, 32'h0, 32'h5, 5'd7, 1'b0, 32'h5, 4'h0, 1'b0}, 1'b0);
    step_check("no_we");

    // bubble
    ms_to_ws_valid = 0;
    @(posedge clk); #1;
    chk("bubble.wen", {28'd0, rf_wen}, 32'd0);
    chk("bubble.fwd", {31'd0, ws_fwd_valid}, 32'd0);

    // back-to-back ALU writes
    for (int i = 1; i <= 3; i++) begin
      drive('{LD_ALU, 2'd0, 32'h0, 32'h0, i, 5'(i), 1'b1, i, 4'hF, 1'b1}, 1'b0);
      step_check($sformatf("b2b%0d", i));
    end

    // flush with simultaneous accept: held instruction still writes this cycle
    drive('{LD_ALU, 2'd0, 32'h0, 32'h0, 32'h44, 5'd4, 1'b1, 32'h44, 4'hF, 1'b1}, 1'b0);
    step_check("pre_flush");
    drive('{LD_ALU, 2'd0, 32'h0, 32'h0, 32'h55, 5'd5, 1'b1, 32'h55, 4'hF, 1'b1}, 1'b1);
    #1;
    chk_out("flush_cycle", e);
    @(posedge clk); #1;
    chk("post_flush.wen", {28'd0, rf_wen}, 32'd0);
    chk("post_flush.fwd", {31'd0, ws_fwd_valid}, 32'd0);
    chk("post_flush.waddr", {27'd0, rf_waddr}, 32'd4);
    ws_flush = 0;

    // asynchronous reset mid-stream
    drive('{LD_ALU, 2'd0, 32'h0, 32'h0, 32'h66, 5'd6, 1'b1, 32'h66, 4'hF, 1'b1}, 1'b0);
    step_check("pre_reset");
    #1 resetn = 0;
    #1;
    chk_out("async_reset", '{5'd0, 4'h0, 32'h0, 1'b0});
    ms_to_ws_valid = 0;
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;
    chk_out("after_reset", '{5'd0, 4'h0, 32'h0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage pipelined CPU, directly upstream of the general register file.
- Registers the MEM-stage result and performs load extraction (byte/half sign/zero extension, LWL/LWR merge).
- Drives the register file write port (waddr, 4-bit wen, wdata) and exposes forwarding/hazard info to decode.
- One-entry pipeline buffer with a valid/allow-in handshake and a flush input.

Parameters:
- DATA_WIDTH, 32, datapath width (only 32 is supported).
- ADDR_WIDTH, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- ms_to_ws_valid  in  1  MEM stage presents a valid instruction.
- ws_allowin  out  1  WB can accept this cycle.
- ms_pc  in  32  instruction PC.
- ms_dest  in  5  destination register number.
- ms_rf_we  in  1  instruction writes a register.
- ms_ld_type  in  3  0=ALU, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=LWL, 7=LWR.
- ms_addr_lo  in  2  load address bits [1:0].
- ms_alu_result  in  32  ALU/move result.
- ms_mem_rdata  in  32  aligned word from data memory.
- ms_rt_value  in  32  old rt value, used for LWL/LWR merge.
- ws_flush  in  1  discard the held instruction (exception).
- rf_waddr  out  5  register file write address.
- rf_wen  out  4  register file byte write enables.
- rf_wdata  out  32  register file write data.
- ws_fwd_valid  out  1  WB holds a valid register-writing instruction.
- ws_fwd_dest  out  5  forwarding destination.
- ws_fwd_data  out  32  forwarding data, equal to rf_wdata.

Behaviour:
- State: ws_valid plus the registered copies of all ms_* fields.
- Reset (async, resetn=0): ws_valid=0 and all registered fields=0.
- Therefore on reset: rf_wen=0, rf_waddr=0, rf_wdata=0, ws_fwd_valid=0.
- ws_allowin=1 at all times; WB retires in exactly one cycle, so there is no backpressure.
- Accept: on a rising edge with ms_to_ws_valid=1 and ws_flush=0, capture all ms_* fields and set ws_valid=1.
- Bubble: ms_to_ws_valid=0 sets ws_valid=0.
- Flush: ws_flush=1 clears ws_valid on the next edge; flush wins over a simultaneous accept.
- Flush does not suppress the write of the currently held instruction in the same cycle (it has already committed).
- Latency: an instruction accepted at edge N drives the register file during cycle N..N+1 and is written at edge N+1.
- Write enable: rf_wen = 4'b1111 when ws_valid && rf_we && dest!=0; otherwise 4'b0000.
- The register file zeroes disabled byte lanes, so WB never emits partial enables. LWL/LWR merges are fully formed here.
- rf_waddr = registered dest; rf_wdata = selected result. Both are combinational from state.
- Data selection, little-endian, a = addr_lo, m = mem_rdata, rt = rt_value:
  - ALU: alu_result.
  - LB/LBU: byte m[8a+7:8a], sign-/zero-extended.
  - LH/LHU: half selected by a[1] (a[0] ignored), sign-/zero-extended.
  - LW: m.
  - LWL, a=0..3: {m[7:0],rt[23:0]} / {m[15:0],rt[15:0]} / {m[23:0],rt[7:0]} / m.
  - LWR, a=0..3: m / {rt[31:24],m[31:8]} / {rt[31:16],m[31:16]} / {rt[31:8],m[31:24]}.
- ws_fwd_valid = ws_valid && rf_we && dest!=0; ws_fwd_dest = dest.
- Mid-operation reset clears ws_valid immediately and asynchronously; any pending write is dropped.

Optional Feature:
- Macro: WB_DEBUG_EN.
- When defined, add outputs debug_wb_pc[31:0], debug_wb_rf_wen[3:0], debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0].
- These mirror the registered PC and the rf_* outputs; debug_wb_rf_wen equals rf_wen, so it is 0 on bubbles.
- Reset value of all debug outputs: 0.
- When undefined, the ports and registered PC are absent and ms_pc is left unused.

Decomposition:
- Shared package: DATA_WIDTH, ADDR_WIDTH, LD_* load-type encodings (3-bit), WEN_ALL=4'b1111.
- Sub-module: load_align, a purely combinational extractor/merger (ld_type, addr_lo, mem_rdata, rt_value -> wdata).
- wb_stage holds the pipeline register, handshake and write-enable logic.

Test Plan:
- Reset: resetn=0 mid-stream with ws_valid=1 -> rf_wen=0 and ws_fwd_valid=0 immediately; all outputs 0.
- LB, a=1, m=32'h1234_80FF -> rf_wdata=32'hFFFF_FF80; LBU, same inputs -> 32'h0000_0080; dest=8, rf_wen=4'hF.
- LWL, a=1, m=32'hAABB_CCDD, rt=32'h1122_3344 -> 32'hCCDD_3344; LWR, a=2, same inputs -> 32'h1122_AABB.
- ALU write with dest=0, result=32'hDEAD_BEEF -> rf_wen=0 and ws_fwd_valid=0.
- Flush: ws_flush=1 in the same cycle ms_to_ws_valid=1 (dest=5) -> next cycle ws_valid=0, rf_wen=0; the held instruction still writes in the flush cycle.
- Back-to-back: 3 consecutive ALU instructions, dest 1/2/3, results 1/2/3 -> one write per cycle in order, no bubbles.
